// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard sources in, stage controls out.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_MemRead;
  logic             ex_branch_taken;
  logic             mem_access;
  logic             imem_waitrequest;
  logic             dmem_waitrequest;
  logic             pc_en;
  logic [1:0]       pc_sel;
  logic             tgt_latch;
  logic             ifid_en;
  logic             ifid_clr;
  logic             idex_en;
  logic             idex_clr;
  logic             exmem_en;
  logic             memwb_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_MemRead, ex_branch_taken,
    output mem_access, imem_waitrequest, dmem_waitrequest,
    input  pc_en, pc_sel, tgt_latch,
    input  ifid_en, ifid_clr, idex_en, idex_clr,
    input  exmem_en, memwb_en,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_MemRead, ex_branch_taken,
    input  mem_access, imem_waitrequest, dmem_waitrequest,
    output pc_en, pc_sel, tgt_latch,
    output ifid_en, ifid_clr, idex_en, idex_clr,
    output exmem_en, memwb_en,
    output state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use, redirect and Avalon wait stalls,
// plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic RST_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] MEM_WAIT   = 2'd1;
  localparam logic [1:0] REDIR_WAIT = 2'd2;

  localparam logic [1:0] SEL_PC4  = 2'd0;
  localparam logic [1:0] SEL_LIVE = 2'd1;
  localparam logic [1:0] SEL_HELD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  logic dstall, loaduse, br, imw;
  logic br_go, br_hold, lu, iw;

  logic       pc_en, tgt_latch;
  logic [1:0] pc_sel;
  logic       ifid_en, ifid_clr;
  logic       idex_en, idex_clr;
  logic       exmem_en, memwb_en;

  assign dstall  = hz.mem_access & hz.dmem_waitrequest;
  assign loaduse = hz.ex_MemRead & (hz.ex_rd != '0) &
                   ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                    (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
  assign br  = hz.ex_branch_taken;
  assign imw = hz.imem_waitrequest;

  // Exclusive one-hot of the RUN/MEM_WAIT priority chain
  assign br_go   = br & ~imw;
  assign br_hold = br & imw;
  assign lu      = ~br & loaduse;
  assign iw      = ~br & ~loaduse & imw;

  always_comb begin
    pc_en     = 1'b1;
    pc_sel    = SEL_PC4;
    tgt_latch = 1'b0;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    state_d   = state_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (dstall) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      idex_en   = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
      stall_inc = 1'b1;
      state_d   = (state_q == REDIR_WAIT) ? REDIR_WAIT : MEM_WAIT;
    end else if (state_q == REDIR_WAIT) begin
      // EX holds a bubble here, so a taken branch is not looked at
      pc_sel   = SEL_HELD;
      ifid_clr = 1'b1;
      if (imw) begin
        pc_en     = 1'b0;
        stall_inc = 1'b1;
      end else begin
        flush_inc = 1'b1;
        state_d   = RUN;
      end
    end else begin
      state_d = RUN;
      unique case (1'b1)
        br_go: begin
          pc_sel    = SEL_LIVE;
          ifid_clr  = 1'b1;
          idex_clr  = 1'b1;
          flush_inc = 1'b1;
        end
        br_hold: begin
          pc_en     = 1'b0;
          tgt_latch = 1'b1;
          ifid_clr  = 1'b1;
          idex_clr  = 1'b1;
          state_d   = REDIR_WAIT;
        end
        lu: begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_clr  = 1'b1;
          stall_inc = 1'b1;
        end
        iw: begin
          pc_en     = 1'b0;
          ifid_clr  = 1'b1;
          stall_inc = 1'b1;
        end
        default: ;
      endcase
    end

    if (!RST_n) begin
      pc_en     = 1'b0;
      pc_sel    = SEL_PC4;
      tgt_latch = 1'b0;
      ifid_en   = 1'b0;
      ifid_clr  = 1'b0;
      idex_en   = 1'b0;
      idex_clr  = 1'b0;
      exmem_en  = 1'b0;
      memwb_en  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.pc_en     = pc_en;
  assign hz.pc_sel    = pc_sel;
  assign hz.tgt_latch = tgt_latch;
  assign hz.ifid_en   = ifid_en;
  assign hz.ifid_clr  = ifid_clr;
  assign hz.idex_en   = idex_en;
  assign hz.idex_clr  = idex_clr;
  assign hz.exmem_en  = exmem_en;
  assign hz.memwb_en  = memwb_en;
  assign hz.state     = state_q;
  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;

endmodule
